rvc_fetch_aligner: RTL
======================

Name: rvc_fetch_aligner

Overview:
- Sits between the instruction-memory word stream and the decode stage.
- Accepts naturally aligned 32-bit fetch words and splits them into halfwords.
- Reassembles 32-bit instructions that straddle a word boundary.
- Expands RV32C 16-bit instructions to their 32-bit base equivalents.
- Presents one instruction per handshake with its PC, a compressed flag and an illegal flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset. Bit 1 may be set; bit 0 is ignored.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  flush and restart at redirect_pc (branch/jump/trap).
- redirect_pc  input  32  new PC; bit 0 ignored.
- in_valid  input  1  fetch word valid.
- in_ready  output  1  fetch word accepted when in_valid & in_ready.
- in_addr  input  32  byte address of the word; bits [1:0] are 0.
- in_data  input  32  fetch word, little-endian halfwords.
- inst_valid  output  1  expanded instruction valid.
- inst_ready  input  1  decode accepts.
- inst  output  32  expanded instruction. On illegal, holds {16'b0, raw halfword}.
- inst_pc  output  32  PC of the instruction.
- inst_is_rvc  output  1  source instruction was 16-bit.
- inst_illegal  output  1  illegal or unsupported compressed encoding.

Behaviour:
- Registers:
  - exp_addr: expected word address.
  - hb / hb_pc: buffered upper halfword and its PC.
  - state.
  - Output slot: inst_valid, inst, inst_pc, inst_is_rvc, inst_illegal.
- Reset:
  - All outputs are 0.
  - exp_addr = RESET_PC & ~3.
  - state = SKIP_LO if RESET_PC[1], else ALIGNED.
- slot_free = !inst_valid | inst_ready. The output slot loads only when slot_free. While inst_valid=1 and inst_ready=0, all inst_* outputs hold stable.
- States and transitions:
  - ALIGNED (nothing buffered; next instruction starts at exp_addr):
    - Consume a word.
    - If in_data[1:0]!=2'b11: emit the expansion of in_data[15:0] at in_addr, buffer hb=in_data[31:16] with hb_pc=in_addr+2, go to HALF.
    - Else: emit in_data unchanged, stay in ALIGNED.
    - In both cases exp_addr += 4.
  - HALF (hb holds the start of the next instruction):
    - If hb[1:0]!=2'b11: emit the expansion of hb at hb_pc without consuming input, go to ALIGNED.
    - Else: consume a word, emit {in_data[15:0], hb} at hb_pc with is_rvc=0, set hb=in_data[31:16] and hb_pc=in_addr+2, stay in HALF, exp_addr += 4.
  - SKIP_LO (target is an odd halfword):
    - Consume a word, discard in_data[15:0], buffer in_data[31:16] with hb_pc=in_addr+2.
    - Go to HALF. Nothing is emitted this cycle.
- in_ready = !rst & !redirect_valid & slot_free & (state!=HALF | hb[1:0]==2'b11).
- Stale words: an accepted word with in_addr!=exp_addr is dropped. State, exp_addr and outputs are unchanged. This drains in-flight fetches after a redirect.
- Redirect (priority over everything except rst):
  - In the same cycle: inst_valid<=0, hb discarded, exp_addr<=redirect_pc&~3, state<=SKIP_LO if redirect_pc[1], else ALIGNED.
  - An instruction presented that cycle is cancelled even if inst_ready=1.
- Latency: 1 cycle from word acceptance to inst_valid.
- Throughput: 1 instruction/cycle. Word input stalls for one cycle whenever HALF emits a buffered RVC.
- Address arithmetic is modulo 2^32; wrap from 0xFFFF_FFFC to 0 is legal.
- Expansion covers the full RV32C integer set:
  - Q0: ADDI4SPN, LW, SW.
  - Q1: NOP/ADDI, JAL, LI, ADDI16SP, LUI, SRLI, SRAI, ANDI, SUB, XOR, OR, AND, J, BEQZ, BNEZ.
  - Q2: SLLI, LWSP, JR, MV, EBREAK, JALR, ADD, SWSP.
- The 3-bit compressed register fields map to x8+field.
- Illegal encodings:
  - halfword 0x0000;
  - ADDI4SPN with imm=0;
  - ADDI16SP with imm=0;
  - LUI with imm=0 or rd=2;
  - LWSP with rd=0;
  - JR with rs1=0;
  - shift with inst[12]=1;
  - reserved and floating-point funct3 slots.

Decomposition:
- Shared compressed-instruction package:
  - quadrant and funct3/funct2 constants;
  - compressed format structs and union;
  - immediate-extraction functions.
- Added to that package:
  - the aligner state enum (ALIGNED, HALF, SKIP_LO);
  - base opcode constants (OP_IMM, OP, LUI, LOAD, STORE, BRANCH, JAL, JALR, SYSTEM).
- Sub-module rvc_expander: combinational, 16-bit in; 32-bit out plus illegal out. Instantiated once, fed by a mux between in_data[15:0] and hb.

Test Plan:
- Reset with RESET_PC=0 → inst_valid=0 and in_ready=1 on the first post-reset cycle. Word 0x0000_0013 at 0x0 → next cycle: inst=0x0000_0013, inst_pc=0x0, is_rvc=0.
- Word 0x4505_0001 at 0x0 → first output: inst=0x0000_0013, pc=0x0, is_rvc=1. in_ready=0 for one cycle. Second output: inst=0x0010_0513, pc=0x2.
- Straddle: word 0x0513_0001 at 0x0, then 0x4505_0010 at 0x4 → outputs in order:
  - 0x0000_0013 at 0x0 (rvc);
  - 0x0010_0513 at 0x2 (is_rvc=0);
  - 0x0010_0513 at 0x6 (rvc).
- Redirect to 0x102, then stale word 0x0000_0013 at 0x8 (dropped), then 0x4505_0001 at 0x100 → single output: 0x0010_0513 at 0x102. Nothing is emitted for 0x100.
- Backpressure: hold inst_ready=0 for 3 cycles with an output pending → inst_* stable and in_ready=0. Release → next instruction follows with no loss or duplication.
- Halfword 0x0000 at 0x0 → inst_illegal=1, inst=0x0000_0000, is_rvc=1. 0x6101 (ADDI16SP imm=0) → illegal=1.

Source files
------------

// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared RV32C definitions: quadrant/funct constants, compressed formats, immediate
// extraction and base-ISA encoders, plus the fetch aligner state constants.
package rvc_fetch_aligner_pkg;

  localparam logic [1:0] Quad0 = 2'b00;
  localparam logic [1:0] Quad1 = 2'b01;
  localparam logic [1:0] Quad2 = 2'b10;

  // Quadrant 0 funct3
  localparam logic [2:0] F3Addi4spn = 3'b000;
  localparam logic [2:0] F3Lw       = 3'b010;
  localparam logic [2:0] F3Sw       = 3'b110;
  // Quadrant 1 funct3
  localparam logic [2:0] F3Addi     = 3'b000;
  localparam logic [2:0] F3Jal      = 3'b001;
  localparam logic [2:0] F3Li       = 3'b010;
  localparam logic [2:0] F3Lui      = 3'b011;
  localparam logic [2:0] F3Misc     = 3'b100;
  localparam logic [2:0] F3J        = 3'b101;
  localparam logic [2:0] F3Beqz     = 3'b110;
  localparam logic [2:0] F3Bnez     = 3'b111;
  // Quadrant 2 funct3
  localparam logic [2:0] F3Slli     = 3'b000;
  localparam logic [2:0] F3Lwsp     = 3'b010;
  localparam logic [2:0] F3Jr       = 3'b100;
  localparam logic [2:0] F3Swsp     = 3'b110;

  // Quadrant 1 MISC-ALU funct2 (bits 11:10) and arithmetic funct2 (bits 6:5)
  localparam logic [1:0] F2Srli  = 2'b00;
  localparam logic [1:0] F2Srai  = 2'b01;
  localparam logic [1:0] F2Andi  = 2'b10;
  localparam logic [1:0] F2Sub   = 2'b00;
  localparam logic [1:0] F2Xor   = 2'b01;
  localparam logic [1:0] F2Or    = 2'b10;

  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  // Aligner states
  localparam logic [1:0] StAligned = 2'd0;
  localparam logic [1:0] StHalf    = 2'd1;
  localparam logic [1:0] StSkipLo  = 2'd2;

  typedef struct packed {
    logic [3:0] funct4;
    logic [4:0] rd_rs1;
    logic [4:0] rs2;
    logic [1:0] op;
  } rvc_cr_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic       imm_hi;
    logic [4:0] rd_rs1;
    logic [4:0] imm_lo;
    logic [1:0] op;
  } rvc_ci_t;

  // CL and CS share this layout; rdp is rd' for loads and rs2' for stores
  typedef struct packed {
    logic [2:0] funct3;
    logic [2:0] imm_hi;
    logic [2:0] rs1p;
    logic [1:0] imm_lo;
    logic [2:0] rdp;
    logic [1:0] op;
  } rvc_cl_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic       imm_hi;
    logic [1:0] funct2;
    logic [2:0] rdp;
    logic [4:0] imm_lo;
    logic [1:0] op;
  } rvc_cb_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic       bit12;
    logic [1:0] funct2;
    logic [2:0] rdp;
    logic [1:0] arith;
    logic [2:0] rs2p;
    logic [1:0] op;
  } rvc_ca_t;

  typedef union packed {
    rvc_cr_t     cr;
    rvc_ci_t     ci;
    rvc_cl_t     cl;
    rvc_cb_t     cb;
    rvc_ca_t     ca;
    logic [15:0] raw;
  } rvc_t;

  function automatic logic [4:0] creg(input logic [2:0] r);
    return {2'b01, r};
  endfunction

  function automatic logic [31:0] imm_ci(input logic [15:0] c);
    return {{27{c[12]}}, c[6:2]};
  endfunction

  function automatic logic [31:0] imm_addi4spn(input logic [15:0] c);
    return {22'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
  endfunction

  function automatic logic [31:0] imm_lw(input logic [15:0] c);
    return {25'b0, c[5], c[12:10], c[6], 2'b00};
  endfunction

  function automatic logic [31:0] imm_lwsp(input logic [15:0] c);
    return {24'b0, c[3:2], c[12], c[6:4], 2'b00};
  endfunction

  function automatic logic [31:0] imm_swsp(input logic [15:0] c);
    return {24'b0, c[8:7], c[12:9], 2'b00};
  endfunction

  function automatic logic [31:0] imm_j(input logic [15:0] c);
    return {{21{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [15:0] c);
    return {{24{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
  endfunction

  function automatic logic [31:0] imm_addi16sp(input logic [15:0] c);
    return {{23{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
  endfunction

  function automatic logic [31:0] imm_lui(input logic [15:0] c);
    return {{15{c[12]}}, c[6:2], 12'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpcBranch};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[31:12], rd, opc};
  endfunction

endpackage

// File: rtl/rvc_fetch_aligner_expander.sv
// RV32C to RV32I expander. Purely combinational; illegal encodings return the raw
// halfword zero-extended so decode can report it in a trap value.
module rvc_expander
  import rvc_fetch_aligner_pkg::*;
(
  input  logic [15:0] rvc,
  output logic [31:0] inst,
  output logic        illegal
);

  rvc_t        u;
  logic [31:0] exp;
  logic        ill;

  assign u = rvc;

  always_comb begin
    exp = 32'h0;
    ill = 1'b0;
    case (u.raw[1:0])
      Quad0: begin
        unique case (u.cl.funct3)
          F3Addi4spn: begin
            exp = enc_i(imm_addi4spn(u.raw), 5'd2, 3'b000, creg(u.cl.rdp), OpcOpImm);
            ill = (imm_addi4spn(u.raw) == 32'h0);
          end
          F3Lw: exp = enc_i(imm_lw(u.raw), creg(u.cl.rs1p), 3'b010, creg(u.cl.rdp), OpcLoad);
          F3Sw: exp = enc_s(imm_lw(u.raw), creg(u.cl.rdp), creg(u.cl.rs1p), 3'b010, OpcStore);
          default: ill = 1'b1;
        endcase
      end
      Quad1: begin
        unique case (u.ci.funct3)
          F3Addi: exp = enc_i(imm_ci(u.raw), u.ci.rd_rs1, 3'b000, u.ci.rd_rs1, OpcOpImm);
          F3Jal:  exp = enc_j(imm_j(u.raw), 5'd1);
          F3Li:   exp = enc_i(imm_ci(u.raw), 5'd0, 3'b000, u.ci.rd_rs1, OpcOpImm);
          F3Lui: begin
            if (u.ci.rd_rs1 == 5'd2) begin
              exp = enc_i(imm_addi16sp(u.raw), 5'd2, 3'b000, 5'd2, OpcOpImm);
              ill = (imm_addi16sp(u.raw) == 32'h0);
            end else begin
              exp = enc_u(imm_lui(u.raw), u.ci.rd_rs1, OpcLui);
              ill = (imm_lui(u.raw) == 32'h0);
            end
          end
          F3Misc: begin
            unique case (u.cb.funct2)
              F2Srli: begin
                exp = enc_r(7'b0000000, u.cb.imm_lo, creg(u.cb.rdp), 3'b101, creg(u.cb.rdp),
                            OpcOpImm);
                ill = u.cb.imm_hi;
              end
              F2Srai: begin
                exp = enc_r(7'b0100000, u.cb.imm_lo, creg(u.cb.rdp), 3'b101, creg(u.cb.rdp),
                            OpcOpImm);
                ill = u.cb.imm_hi;
              end
              F2Andi: exp = enc_i(imm_ci(u.raw), creg(u.cb.rdp), 3'b111, creg(u.cb.rdp),
                                  OpcOpImm);
              default: begin
                // bit 12 set selects the RV64-only SUBW/ADDW slots
                if (u.ca.bit12) begin
                  ill = 1'b1;
                end else begin
                  unique case (u.ca.arith)
                    F2Sub: exp = enc_r(7'b0100000, creg(u.ca.rs2p), creg(u.ca.rdp), 3'b000,
                                       creg(u.ca.rdp), OpcOp);
                    F2Xor: exp = enc_r(7'b0000000, creg(u.ca.rs2p), creg(u.ca.rdp), 3'b100,
                                       creg(u.ca.rdp), OpcOp);
                    F2Or:  exp = enc_r(7'b0000000, creg(u.ca.rs2p), creg(u.ca.rdp), 3'b110,
                                       creg(u.ca.rdp), OpcOp);
                    default: exp = enc_r(7'b0000000, creg(u.ca.rs2p), creg(u.ca.rdp), 3'b111,
                                         creg(u.ca.rdp), OpcOp);
                  endcase
                end
              end
            endcase
          end
          F3J:    exp = enc_j(imm_j(u.raw), 5'd0);
          F3Beqz: exp = enc_b(imm_b(u.raw), 5'd0, creg(u.cb.rdp), 3'b000);
          default: exp = enc_b(imm_b(u.raw), 5'd0, creg(u.cb.rdp), 3'b001);
        endcase
      end
      Quad2: begin
        unique case (u.ci.funct3)
          F3Slli: begin
            exp = enc_r(7'b0000000, u.ci.imm_lo, u.ci.rd_rs1, 3'b001, u.ci.rd_rs1, OpcOpImm);
            ill = u.ci.imm_hi;
          end
          F3Lwsp: begin
            exp = enc_i(imm_lwsp(u.raw), 5'd2, 3'b010, u.ci.rd_rs1, OpcLoad);
            ill = (u.ci.rd_rs1 == 5'd0);
          end
          F3Jr: begin
            if (!u.cr.funct4[0]) begin
              if (u.cr.rs2 == 5'd0) begin
                exp = enc_i(32'h0, u.cr.rd_rs1, 3'b000, 5'd0, OpcJalr);
                ill = (u.cr.rd_rs1 == 5'd0);
              end else begin
                exp = enc_r(7'b0000000, u.cr.rs2, 5'd0, 3'b000, u.cr.rd_rs1, OpcOp);
              end
            end else if (u.cr.rs2 != 5'd0) begin
              exp = enc_r(7'b0000000, u.cr.rs2, u.cr.rd_rs1, 3'b000, u.cr.rd_rs1, OpcOp);
            end else if (u.cr.rd_rs1 == 5'd0) begin
              exp = enc_i(32'h1, 5'd0, 3'b000, 5'd0, OpcSystem);
            end else begin
              exp = enc_i(32'h0, u.cr.rd_rs1, 3'b000, 5'd1, OpcJalr);
            end
          end
          F3Swsp: exp = enc_s(imm_swsp(u.raw), u.cr.rs2, 5'd2, 3'b010, OpcStore);
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  end

  assign illegal = ill;
  assign inst    = ill ? {16'h0, u.raw} : exp;

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetch aligner: splits aligned fetch words into halfwords, rejoins straddling 32-bit
// instructions and expands RVC, presenting one instruction per handshake to decode.
module rvc_fetch_aligner
  import rvc_fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_rvc,
  output logic        inst_illegal
);

  localparam logic [31:0] ResetWordAddr = RESET_PC & ~32'h3;
  localparam logic [1:0]  ResetState    = RESET_PC[1] ? StSkipLo : StAligned;

  logic [1:0]  state_q, state_d;
  logic [31:0] exp_addr_q, exp_addr_d;
  logic [15:0] hb_q, hb_d;
  logic [31:0] hb_pc_q, hb_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_is_rvc_q, inst_is_rvc_d;
  logic        inst_illegal_q, inst_illegal_d;

  logic        slot_free;
  logic        hb_is_rvc;
  logic        word_ok;
  logic [15:0] exp_in;
  logic [31:0] exp_inst;
  logic        exp_illegal;

  assign slot_free = !inst_valid_q || inst_ready;
  assign hb_is_rvc = (hb_q[1:0] != 2'b11);
  assign in_ready  = !rst && !redirect_valid && slot_free && (state_q != StHalf || !hb_is_rvc);
  // Words not at the expected address are in-flight fetches from before a redirect
  assign word_ok   = in_valid && in_ready && (in_addr == exp_addr_q);

  assign exp_in = (state_q == StHalf) ? hb_q : in_data[15:0];

  rvc_expander u_expander (
    .rvc     (exp_in),
    .inst    (exp_inst),
    .illegal (exp_illegal)
  );

  always_comb begin
    state_d        = state_q;
    exp_addr_d     = exp_addr_q;
    hb_d           = hb_q;
    hb_pc_d        = hb_pc_q;
    inst_valid_d   = inst_valid_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    inst_is_rvc_d  = inst_is_rvc_q;
    inst_illegal_d = inst_illegal_q;

    if (slot_free) begin
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      StAligned: begin
        if (word_ok) begin
          exp_addr_d   = exp_addr_q + 32'd4;
          inst_valid_d = 1'b1;
          inst_pc_d    = in_addr;
          if (in_data[1:0] != 2'b11) begin
            inst_d         = exp_inst;
            inst_is_rvc_d  = 1'b1;
            inst_illegal_d = exp_illegal;
            hb_d           = in_data[31:16];
            hb_pc_d        = in_addr + 32'd2;
            state_d        = StHalf;
          end else begin
            inst_d         = in_data;
            inst_is_rvc_d  = 1'b0;
            inst_illegal_d = 1'b0;
          end
        end
      end
      StHalf: begin
        if (hb_is_rvc) begin
          if (slot_free) begin
            inst_valid_d   = 1'b1;
            inst_d         = exp_inst;
            inst_pc_d      = hb_pc_q;
            inst_is_rvc_d  = 1'b1;
            inst_illegal_d = exp_illegal;
            state_d        = StAligned;
          end
        end else if (word_ok) begin
          inst_valid_d   = 1'b1;
          inst_d         = {in_data[15:0], hb_q};
          inst_pc_d      = hb_pc_q;
          inst_is_rvc_d  = 1'b0;
          inst_illegal_d = 1'b0;
          hb_d           = in_data[31:16];
          hb_pc_d        = in_addr + 32'd2;
          exp_addr_d     = exp_addr_q + 32'd4;
        end
      end
      StSkipLo: begin
        if (word_ok) begin
          hb_d       = in_data[31:16];
          hb_pc_d    = in_addr + 32'd2;
          exp_addr_d = exp_addr_q + 32'd4;
          state_d    = StHalf;
        end
      end
      default: state_d = StAligned;
    endcase

    if (redirect_valid) begin
      inst_valid_d = 1'b0;
      hb_d         = 16'h0;
      exp_addr_d   = redirect_pc & ~32'h3;
      state_d      = redirect_pc[1] ? StSkipLo : StAligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ResetState;
      exp_addr_q     <= ResetWordAddr;
      hb_q           <= 16'h0;
      hb_pc_q        <= 32'h0;
      inst_valid_q   <= 1'b0;
      inst_q         <= 32'h0;
      inst_pc_q      <= 32'h0;
      inst_is_rvc_q  <= 1'b0;
      inst_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      exp_addr_q     <= exp_addr_d;
      hb_q           <= hb_d;
      hb_pc_q        <= hb_pc_d;
      inst_valid_q   <= inst_valid_d;
      inst_q         <= inst_d;
      inst_pc_q      <= inst_pc_d;
      inst_is_rvc_q  <= inst_is_rvc_d;
      inst_illegal_q <= inst_illegal_d;
    end
  end

  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign inst_is_rvc  = inst_is_rvc_q;
  assign inst_illegal = inst_illegal_q;

endmodule
